// File: rtl/prog_pkg.sv
// Shared constants and FSM state encoding for the program-memory readback engine.
package prog_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/program_reader_if.sv
// Host/memory-side signal bundle of program_reader; master is the reader, slave is the host + memory.
interface program_reader_if #(
  parameter int ADDR_W = prog_pkg::ADDR_W,
  parameter int DATA_W = prog_pkg::DATA_W
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W-1:0] endAddr;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] memData;
  logic              dataReady;
  logic [ADDR_W-1:0] address;
  logic              RMout;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic [DATA_W-1:0] checksum;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, startAddr, endAddr, PC, memData, dataReady,
    output address, RMout, dataOut, dataValid, checksum, busy, done
  );

  modport slave (
    output start, abort, startAddr, endAddr, PC, memData, dataReady,
    input  address, RMout, dataOut, dataValid, checksum, busy, done
  );
endinterface

// File: rtl/counter.sv
// Loadable up-counter; load wins over increment, wraps naturally at 2^W.
module counter #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = in;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;
endmodule

// File: rtl/mux15_2_1.sv
// 2:1 bus select: in1 when sel is high, otherwise in0.
module mux15_2_1 #(
  parameter int W = 15
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/program_reader.sv
// Program-memory readback engine: sweeps [startAddr..endAddr] (wrapping), streams words
// over valid/ready and accumulates a mod-2^DATA_W checksum of accepted words.
module program_reader #(
  parameter int ADDR_W = prog_pkg::ADDR_W,
  parameter int DATA_W = prog_pkg::DATA_W
) (
  input logic              clk,
  input logic              reset,
  program_reader_if.master bus
);
  import prog_pkg::*;

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] end_d, end_q;
  logic [DATA_W-1:0] dout_d, dout_q;
  logic [DATA_W-1:0] csum_d, csum_q;
  logic [ADDR_W-1:0] cnt;
  logic              idle, rd_mode, load, last, accept, inc;

  assign idle    = (state_q == IDLE);
  assign rd_mode = ~idle;
  assign load    = idle & bus.start;
  assign last    = (cnt == end_q);
  // abort outranks a same-cycle handshake: the word is neither counted nor summed
  assign accept  = (state_q == SEND) & bus.dataReady & ~bus.abort;
  assign inc     = accept & ~last;

  counter #(.W(ADDR_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .inc   (inc),
    .in    (bus.startAddr),
    .out   (cnt)
  );

  mux15_2_1 #(.W(ADDR_W)) u_addr_mux (
    .sel (rd_mode),
    .in0 (bus.PC),
    .in1 (cnt),
    .out (bus.address)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    state_d = CAPT;
      CAPT:    state_d = SEND;
      SEND:    if (accept) state_d = last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_mode && bus.abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    end_d  = end_q;
    dout_d = dout_q;
    csum_d = csum_q;
    if (load) begin
      end_d  = bus.endAddr;
      csum_d = '0;
    end
    // memory read data belongs to the address presented during READ
    if (state_q == CAPT) begin
      dout_d = bus.memData;
    end
    if (accept) begin
      csum_d = csum_q + dout_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      end_q   <= '0;
      dout_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      dout_q  <= dout_d;
      csum_q  <= csum_d;
    end
  end

  assign bus.RMout     = rd_mode;
  assign bus.busy      = rd_mode;
  assign bus.dataOut   = dout_q;
  assign bus.dataValid = (state_q == SEND);
  assign bus.checksum  = csum_q;
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_program_reader.sv
// Randomized bench for program_reader: a reference model derives the expected word/address
// stream, checksum and cycle count of each dump from the range rules.
module tb_program_reader;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_reader_if pif ();

  program_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  logic [DW-1:0] mem [0:32767];
  always @(posedge clk) pif.memData <= mem[pif.address];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input string nm, input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input int stall_pct, input int stall_word, input int abort_word,
                          input bit noise);
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] got_w[$];
    logic [AW-1:0] got_a[$];
    logic [AW-1:0] a;
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] prev_do;
    int k, first_v, n_done, rm_cyc, stalls, exp_n, stall_left;
    bit fin, aborting, prev_hold;

    a = s;
    while (1) begin
      exp_addr.push_back(a);
      if (a == e) break;
      a = a + 1'b1;
    end
    exp_n = (abort_word >= 0) ? abort_word : exp_addr.size();
    exp_sum = '0;
    for (int i = 0; i < exp_n; i++) exp_sum = exp_sum + mem[exp_addr[i]];

    @(posedge clk); #1;
    pif.PC = AW'($urandom);
    pif.start = 1'b1; pif.startAddr = s; pif.endAddr = e;
    pif.dataReady = 1'b0; pif.abort = 1'b0;
    @(posedge clk); #1;
    pif.start = 1'b0;
    pif.startAddr = AW'($urandom); pif.endAddr = AW'($urandom);
    chk({nm, ".rm_e0"}, 32'(pif.RMout), 32'd1);
    chk({nm, ".addr_e0"}, 32'(pif.address), 32'(s));

    k = 0; first_v = -1; n_done = 0; rm_cyc = 0; stalls = 0;
    fin = 1'b0; aborting = 1'b0; prev_hold = 1'b0; prev_do = '0; stall_left = 5;
    while (!fin && k < 2000) begin
      pif.PC = AW'($urandom);
      pif.dataReady = ($urandom_range(0, 99) >= stall_pct);
      pif.abort = 1'b0;
      pif.start = noise && ($urandom_range(0, 3) == 0);
      if (pif.start) begin
        pif.startAddr = AW'($urandom); pif.endAddr = AW'($urandom);
      end
      if (pif.dataValid && got_w.size() == stall_word && stall_left > 0) begin
        pif.dataReady = 1'b0;
        stall_left--;
      end
      if (abort_word >= 0 && pif.dataValid && got_w.size() == abort_word) begin
        pif.abort = 1'b1; pif.dataReady = 1'b1; aborting = 1'b1;
      end
      @(negedge clk);
      if (prev_hold) begin
        chk({nm, ".hold_valid"}, 32'(pif.dataValid), 32'd1);
        chk({nm, ".hold_data"}, 32'(pif.dataOut), 32'(prev_do));
      end
      if (pif.RMout) rm_cyc++;
      if (pif.dataValid && first_v < 0) first_v = k;
      if (pif.done) n_done++;
      prev_hold = pif.dataValid && !pif.dataReady && !pif.abort;
      if (prev_hold) stalls++;
      prev_do = pif.dataOut;
      if (pif.dataValid && pif.dataReady && !pif.abort) begin
        got_w.push_back(pif.dataOut);
        got_a.push_back(pif.address);
      end
      if (pif.done || aborting) fin = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    pif.start = 1'b0; pif.abort = 1'b0; pif.dataReady = 1'b0;
    pif.PC = AW'($urandom);
    #1;
    chk({nm, ".finished"}, 32'(fin), 32'd1);
    chk({nm, ".rm_after"}, 32'(pif.RMout), 32'd0);
    chk({nm, ".busy_after"}, 32'(pif.busy), 32'd0);
    chk({nm, ".valid_after"}, 32'(pif.dataValid), 32'd0);
    chk({nm, ".done_after"}, 32'(pif.done), 32'd0);
    chk({nm, ".addr_is_pc"}, 32'(pif.address), 32'(pif.PC));
    chk({nm, ".n_words"}, 32'(got_w.size()), 32'(exp_n));
    for (int i = 0; i < got_w.size() && i < exp_n; i++) begin
      chk($sformatf("%s.word%0d", nm, i), 32'(got_w[i]), 32'(mem[exp_addr[i]]));
      chk($sformatf("%s.addr%0d", nm, i), 32'(got_a[i]), 32'(exp_addr[i]));
    end
    chk({nm, ".checksum"}, 32'(pif.checksum), 32'(exp_sum));
    chk({nm, ".done_pulses"}, 32'(n_done), (abort_word >= 0) ? 32'd0 : 32'd1);
    chk({nm, ".first_valid"}, 32'(first_v), 32'd2);
    if (abort_word < 0)
      chk({nm, ".rm_cycles"}, 32'(rm_cyc), 32'(3 * exp_n + stalls + 1));
    @(negedge clk);
    chk({nm, ".csum_hold"}, 32'(pif.checksum), 32'(exp_sum));
    chk({nm, ".no_late_done"}, 32'(pif.done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rs;
    reset = 1'b1;
    pif.start = 1'b0; pif.abort = 1'b0; pif.dataReady = 1'b0;
    pif.startAddr = '0; pif.endAddr = '0; pif.PC = AW'($urandom);
    for (int i = 0; i < 32768; i++) mem[i] = DW'($urandom);
    #1;
    chk("rst.rm", 32'(pif.RMout), 32'd0);
    chk("rst.busy", 32'(pif.busy), 32'd0);
    chk("rst.valid", 32'(pif.dataValid), 32'd0);
    chk("rst.done", 32'(pif.done), 32'd0);
    chk("rst.dout", 32'(pif.dataOut), 32'd0);
    chk("rst.csum", 32'(pif.checksum), 32'd0);
    chk("rst.addr", 32'(pif.address), 32'(pif.PC));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    mem[15'h0010] = 16'hBEEF;
    run_dump("single", 15'h0010, 15'h0010, 0, -1, -1, 1'b0);

    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    run_dump("stall", 15'h0000, 15'h0003, 0, 1, -1, 1'b0);
    chk("stall.csum_a", 32'(pif.checksum), 32'h000A);

    run_dump("wrap", 15'h7FFE, 15'h0001, 20, -1, -1, 1'b0);

    run_dump("abort", 15'h0200, 15'h0207, 0, -1, 1, 1'b0);

    // async reset in the middle of CAPT
    @(posedge clk); #1;
    pif.start = 1'b1; pif.startAddr = 15'h0100; pif.endAddr = 15'h0105;
    @(posedge clk); #1;
    pif.start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst.rm", 32'(pif.RMout), 32'd0);
    chk("arst.busy", 32'(pif.busy), 32'd0);
    chk("arst.valid", 32'(pif.dataValid), 32'd0);
    chk("arst.done", 32'(pif.done), 32'd0);
    chk("arst.dout", 32'(pif.dataOut), 32'd0);
    chk("arst.csum", 32'(pif.checksum), 32'd0);
    chk("arst.addr", 32'(pif.address), 32'(pif.PC));
    @(negedge clk);
    reset = 1'b0;
    run_dump("post_rst", 15'h0100, 15'h0105, 10, -1, -1, 1'b0);

    mem[15'h0300] = 16'hFFFF; mem[15'h0301] = 16'h0002;
    run_dump("ovf", 15'h0300, 15'h0301, 0, -1, -1, 1'b1);
    chk("ovf.csum_a", 32'(pif.checksum), 32'h0001);

    for (int t = 0; t < 6; t++) begin
      rs = AW'($urandom);
      run_dump($sformatf("rnd%0d", t), rs, rs + AW'($urandom_range(0, 7)), 30, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/program_reader.md
# program_reader

Program-memory readback engine: the read-side counterpart of the program loader. On request it takes over the 15-bit program-memory address bus from the CPU PC and sweeps an inclusive address range. It streams each 16-bit word out over a valid/ready handshake and keeps a running checksum, so the host can dump a loaded program or verify it.

## Interface

Parameters:
- ADDR_W, default 15, program-memory address width.
- DATA_W, default 16, program word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  cancel the dump in progress.
- startAddr  input  15  first address of the range.
- endAddr  input  15  last address of the range, inclusive.
- PC  input  15  CPU program counter; passed to memory when not dumping.
- memData  input  16  program-memory read data; synchronous read, valid the cycle after the address.
- dataReady  input  1  downstream accepts dataOut.
- address  output  15  program-memory address.
- RMout  output  1  read mode active; CPU must stall while high.
- dataOut  output  16  registered word being offered.
- dataValid  output  1  dataOut is valid.
- checksum  output  16  sum of accepted words, mod 2^16.
- busy  output  1  engine not in IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

## Operation

- States:
  - IDLE: RMout=0.
  - READ: address=counter.
  - CAPT: address held; memData registered into dataOut at the end of the cycle.
  - SEND: dataValid=1.
  - DONE: done=1.
- Address mux (combinational): address = RMout ? counter : PC. RMout = busy = (state != IDLE).
- IDLE→READ on start: counter←startAddr, checksum←0.
- READ→CAPT unconditionally.
- CAPT→SEND unconditionally.
- SEND, dataValid & dataReady:
  - checksum←checksum+dataOut.
  - If counter==endAddr, go to DONE.
  - Otherwise counter←counter+1 and go to READ.
- SEND, no handshake: hold state; dataOut stable.
- DONE→IDLE unconditionally.
- Wrap-around: counter increments 15'h7FFF→15'h0000. If endAddr<startAddr, the sweep wraps and ends at endAddr.
- startAddr==endAddr: exactly one word.
- start while busy: ignored.
- startAddr and endAddr are sampled only at start. endAddr is latched internally.
- abort in any non-IDLE state: next state IDLE.
  - dataValid drops next cycle and no done pulse is issued.
  - checksum keeps its partial value.
  - abort has priority over a same-cycle handshake, and that word is not added.
- checksum holds after DONE/abort until the next accepted start.

## Timing

- Reset values: address=PC (combinational), RMout=0, dataOut=0, dataValid=0, checksum=0, busy=0, done=0. State=IDLE.
- Reset mid-operation clears everything immediately, asynchronously; the bus returns to PC.
- start sampled at edge E0. RMout/address=startAddr from E0. dataValid high from E2.
- Per word: at least 3 cycles (READ, CAPT, SEND). Back-pressure extends SEND only.
- The final handshake at edge Ek gives done=1 for one cycle in [Ek, Ek+1) and RMout=0 from Ek+1.
- dataValid never deasserts without a handshake, except on abort/reset.

## Structure

- Shared package prog_pkg holds:
  - ADDR_W and DATA_W constants.
  - the state enum (IDLE, READ, CAPT, SEND, DONE), 3-bit encoding.
- Address counter is the existing counter module: in=startAddr, load=start&idle, inc=handshake&~last.
- The 2:1 address select is the existing mux15_2_1.
- The FSM, data/checksum registers and endAddr latch live in program_reader.

## Test plan

- Single word: startAddr=endAddr=15'h0010, mem[0x10]=16'hBEEF, dataReady=1. Expect:
  - one dataValid at E2 with dataOut=BEEF;
  - checksum=BEEF;
  - done pulse;
  - RMout=1 for exactly 4 cycles.
- Range 0x0000–0x0003 holding 1,2,3,4, dataReady held 0 for 5 cycles on word 2. Expect:
  - dataOut stable at 2 during the stall;
  - words 1,2,3,4 in order;
  - checksum=16'h000A.
- Wrap: startAddr=15'h7FFE, endAddr=15'h0001. Expect addresses 7FFE, 7FFF, 0000, 0001, then done.
- Abort during SEND of the 2nd word. Expect:
  - dataValid=0 next cycle;
  - no done pulse;
  - checksum equals the 1st word only;
  - address=PC.
- Async reset asserted mid-CAPT. Expect all outputs at reset values immediately. A subsequent start works normally.
- Checksum overflow: words FFFF, 0002. Expect checksum=16'h0001. A start while busy has no effect on the range.
